// File: rtl/module_icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains above byte offset, word offset and index.
  function automatic int tag_w(input int lines, input int words);
    return 32 - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/module_icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface module_icache_if;
  logic [31:0] pc_i;
  logic [31:0] instr_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  modport slave (
    input  pc_i, flush_i, mem_rdata_i, mem_rvalid_i,
    output instr_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output pc_i, flush_i, mem_rdata_i, mem_rvalid_i,
    input  instr_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/module_icache_tagram.sv
// Valid/tag store: async read, single write port, bulk clear; only valid bits reset.
module module_icache_tagram #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clear
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];

  // Clear wins over a simultaneous fill so a pending flush also drops the new line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

endmodule

// File: rtl/module_icache.sv
// Direct-mapped read-only instruction cache with combinational hit path and
// a two-state refill FSM fed by word-wide beats from backing memory.
module module_icache
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  module_icache_if.slave  bus
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);

  icache_state_t    state, state_n;
  logic [OFF_W-1:0] beat_cnt, beat_cnt_n;
  logic             flush_pend, flush_pend_n;
  logic             mem_req_q, mem_req_n;
  logic [31:0]      mem_addr_q, mem_addr_n;
  logic             tag_we, data_we, clear_all;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag, rd_tag;
  logic             rd_valid, hit;
  logic [31:0]      data_mem [LINES*WORDS];
  logic             unused_bits;

  assign pc_off   = bus.pc_i[2 +: OFF_W];
  assign pc_idx   = bus.pc_i[2+OFF_W +: IDX_W];
  assign pc_tag   = bus.pc_i[31 -: TAG_W];
  assign fill_idx = mem_addr_q[2+OFF_W +: IDX_W];
  assign fill_tag = mem_addr_q[31 -: TAG_W];
  assign unused_bits = ^{bus.pc_i[1:0], mem_addr_q[2+OFF_W-1:0]};

  module_icache_tagram #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tagram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (tag_we),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .clear    (clear_all)
  );

  // Lookups only resolve in IDLE, so fresh refill data is never seen mid-fill.
  assign hit         = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
  assign bus.stall_o = !hit;
  assign bus.instr_o = hit ? data_mem[{pc_idx, pc_off}] : NOP_INSTR;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

  always_comb begin
    state_n      = state;
    beat_cnt_n   = beat_cnt;
    flush_pend_n = flush_pend;
    mem_req_n    = 1'b0;
    mem_addr_n   = mem_addr_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    clear_all    = 1'b0;
    if (state == IDLE) begin
      clear_all = bus.flush_i;
      if (!hit) begin
        state_n    = REFILL;
        mem_req_n  = 1'b1;
        mem_addr_n = {bus.pc_i[31:2+OFF_W], {(2+OFF_W){1'b0}}};
      end
    end else begin
      if (bus.flush_i) flush_pend_n = 1'b1;
      if (bus.mem_rvalid_i) begin
        data_we    = 1'b1;
        beat_cnt_n = beat_cnt + 1'b1;
        if (beat_cnt == OFF_W'(WORDS-1)) begin
          tag_we       = 1'b1;
          beat_cnt_n   = '0;
          state_n      = IDLE;
          clear_all    = flush_pend_n;
          flush_pend_n = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_cnt_n;
      flush_pend <= flush_pend_n;
      mem_req_q  <= mem_req_n;
      mem_addr_q <= mem_addr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we) data_mem[{fill_idx, beat_cnt}] <= bus.mem_rdata_i;
  end

endmodule

// File: tb/tb_module_icache.sv
// Bench for module_icache: line-level reference model, beat-serving memory and directed scenarios.
module tb_module_icache;
  import icache_pkg::*;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OB    = $clog2(WORDS);
  localparam int IB    = $clog2(LINES);

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  module_icache_if bus();

  module_icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int gap = 0;
  int req_pulses = 0;

  // Backing memory contents: words 0..3 are 0x11..0x44, elsewhere a tagged address.
  function automatic logic [31:0] bmem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h10) return 32'h11 * ((w >> 2) + 1);
    return 32'hC0DE_0000 | {16'h0, w[15:0]};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(WORDS*4 - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    logic [IB-1:0] i;
    i = a[2+OB +: IB];
    return int'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which line addresses are resident, and whether a refill is open.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  bit          m_ref, m_pend, m_req;
  logic [31:0] m_addr = '0;
  int          m_beats;

  function automatic bit m_hit(input logic [31:0] a);
    return !m_ref && m_valid[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    bit h;
    forever begin
      @(posedge clk or negedge rst_i);
      if (!rst_i) begin
        m_clear();
        m_ref = 0; m_pend = 0; m_req = 0; m_addr = '0; m_beats = 0;
      end else if (!m_ref) begin
        h = m_hit(bus.pc_i);
        if (bus.flush_i) m_clear();
        m_req = 0;
        if (!h) begin
          m_ref = 1; m_req = 1; m_addr = line_of(bus.pc_i); m_beats = 0;
        end
      end else begin
        m_req = 0;
        if (bus.flush_i) m_pend = 1;
        if (bus.mem_rvalid_i) begin
          m_beats++;
          if (m_beats == WORDS) begin
            m_ref = 0;
            m_valid[idx_of(m_addr)] = 1'b1;
            m_line[idx_of(m_addr)]  = m_addr;
            if (m_pend) m_clear();
            m_pend = 0;
          end
        end
      end
    end
  end

  initial begin
    bit es;
    forever begin
      @(negedge clk);
      es = !m_hit(bus.pc_i);
      chk("model_stall", {31'b0, bus.stall_o}, {31'b0, es});
      chk("model_instr", bus.instr_o, es ? NOP_INSTR : bmem(bus.pc_i));
      chk("model_req", {31'b0, bus.mem_req_o}, {31'b0, m_req});
      chk("model_addr", bus.mem_addr_o, m_addr);
      if (bus.mem_req_o) req_pulses++;
    end
  end

  // Memory responder: one line per request, ascending words, optional gap between beats.
  initial begin
    logic [31:0] a;
    bit abort;
    int lim;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_i && bus.mem_req_o) begin
        a = bus.mem_addr_o;
        abort = 0;
        for (int b = 0; b < WORDS && !abort; b++) begin
          lim = (b == 0) ? 0 : gap;
          for (int g = 0; g <= lim && !abort; g++) begin
            @(posedge clk); #1;
            if (!rst_i) abort = 1;
            else begin
              bus.mem_rvalid_i = (g == lim);
              bus.mem_rdata_i  = bmem(a + 32'(4*b));
            end
          end
        end
        if (!abort) begin @(posedge clk); #1; end
        bus.mem_rvalid_i = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_unstall(input int maxc, input string name);
    int n;
    n = 0;
    while (bus.stall_o && n < maxc) begin tick(); n++; end
    chk(name, {31'b0, bus.stall_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc_i = '0;
    bus.flush_i = 1'b0;
    rst_i = 1'b0;
    tick(3);
    rst_i = 1'b1;

    // Cold miss at 0x00, back-to-back beats.
    #1;
    chk("cold_c0_stall", {31'b0, bus.stall_o}, 32'd1);
    chk("cold_c0_instr", bus.instr_o, 32'h0000_0013);
    tick();
    chk("cold_c1_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("cold_c1_addr", bus.mem_addr_o, 32'h0);
    tick();
    chk("cold_c2_req", {31'b0, bus.mem_req_o}, 32'd0);
    tick(3);
    chk("cold_c5_stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("cold_c6_stall", {31'b0, bus.stall_o}, 32'd0);
    chk("cold_c6_instr", bus.instr_o, 32'h11);
    bus.pc_i = 32'h04; #1;
    chk("cold_pc4_stall", {31'b0, bus.stall_o}, 32'd0);
    chk("cold_pc4_instr", bus.instr_o, 32'h22);

    // Mid-line miss.
    bus.pc_i = 32'h2C; #1;
    chk("mid_stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("mid_addr", bus.mem_addr_o, 32'h20);
    wait_unstall(20, "mid_timeout");
    chk("mid_instr", bus.instr_o, 32'hC0DE_002C);

    // Conflict on index 0.
    bus.pc_i = 32'h100; #1;
    chk("conf_stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("conf_addr", bus.mem_addr_o, 32'h100);
    wait_unstall(20, "conf_timeout");
    chk("conf_instr", bus.instr_o, 32'hC0DE_0100);
    bus.pc_i = 32'h00; #1;
    chk("conf_back_stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("conf_back_addr", bus.mem_addr_o, 32'h00);
    wait_unstall(20, "conf_back_timeout");
    chk("conf_back_instr", bus.instr_o, 32'h11);

    // Gapped beats.
    gap = 3;
    bus.pc_i = 32'h40;
    req_pulses = 0;
    tick();
    chk("gap_addr", bus.mem_addr_o, 32'h40);
    wait_unstall(60, "gap_timeout");
    chk("gap_req_pulses", 32'(req_pulses), 32'd1);
    for (int i = 0; i < WORDS; i++) begin
      bus.pc_i = 32'h40 + 32'(4*i); #1;
      chk("gap_word", bus.instr_o, 32'hC0DE_0040 + 32'(4*i));
    end
    gap = 0;

    // Flush in IDLE: same-cycle lookup still hits, next access misses.
    bus.pc_i = 32'h44;
    bus.flush_i = 1'b1; #1;
    chk("fl_idle_same", {31'b0, bus.stall_o}, 32'd0);
    tick();
    bus.flush_i = 1'b0; #1;
    chk("fl_idle_next", {31'b0, bus.stall_o}, 32'd1);
    wait_unstall(20, "fl_idle_timeout");
    chk("fl_idle_instr", bus.instr_o, 32'hC0DE_0044);

    // Flush during REFILL: line completes, then same PC refills again.
    bus.pc_i = 32'h80;
    req_pulses = 0;
    tick(2);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    wait_unstall(40, "fl_ref_timeout");
    chk("fl_ref_pulses", 32'(req_pulses), 32'd2);
    chk("fl_ref_instr", bus.instr_o, 32'hC0DE_0080);

    // Reset after two beats of a refill.
    bus.pc_i = 32'h200;
    tick(4);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    #1 rst_i = 1'b1;
    bus.pc_i = 32'h80; #1;
    chk("rst_old_line_miss", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("rst_fresh_req", {31'b0, bus.mem_req_o}, 32'd1);
    chk("rst_fresh_addr", bus.mem_addr_o, 32'h80);
    wait_unstall(20, "rst_fresh_timeout");
    chk("rst_fresh_instr", bus.instr_o, 32'hC0DE_0080);
    bus.pc_i = 32'h200; #1;
    chk("rst_partial_miss", {31'b0, bus.stall_o}, 32'd1);
    tick();
    chk("rst_partial_addr", bus.mem_addr_o, 32'h200);
    wait_unstall(20, "rst_partial_timeout");
    chk("rst_partial_instr", bus.instr_o, 32'hC0DE_0200);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
